// File: rtl/edf_irq_sink.sv
// rtl/edf_irq_sink.sv - EDF interrupt sink: claims earlier-deadline winners and tracks nesting on a deadline stack.
// Optional deadline-miss detection is compiled in with EDF_IRQ_SINK_MISS_EN.
module edf_irq_sink #(
    parameter int NrIrqs  = 4,
    parameter int TsWidth = 24,
    parameter int Depth   = 4,
    localparam int IdWidth = $clog2(NrIrqs),
    localparam int DpWidth = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               irq_valid_i,
    input  logic [IdWidth-1:0] irq_id_i,
    input  logic [TsWidth-1:0] irq_dl_i,
    output logic               irq_ack_o,
    output logic [IdWidth-1:0] irq_id_o,
    output logic               core_irq_req_o,
    output logic [IdWidth-1:0] core_irq_id_o,
    input  logic               core_irq_ack_i,
    input  logic               core_mret_i,
    input  logic [63:0]        mtime_i,
    output logic [IdWidth-1:0] cur_id_o,
    output logic [TsWidth-1:0] cur_dl_o,
    output logic [DpWidth-1:0] depth_o,
    output logic               dl_miss_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLAIM,
        S_NOTIFY
    } state_e;

    localparam logic [DpWidth-1:0] DepthMax = DpWidth'(Depth);

    // Wrap-aware ordering: a is earlier than b when (a-b) is negative modulo 2^TsWidth.
    function automatic logic earlier(input logic [TsWidth-1:0] a, input logic [TsWidth-1:0] b);
        logic [TsWidth-1:0] diff;
        diff = a - b;
        return diff[TsWidth-1];
    endfunction

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [IdWidth-1:0] r_pend_id;
    logic [TsWidth-1:0] r_pend_dl;
    logic [DpWidth-1:0] r_depth;
    // Entry 0 is always the top; emptied slots are zeroed so the top reads 0 when empty.
    logic [IdWidth-1:0] r_stk_id [Depth];
    logic [TsWidth-1:0] r_stk_dl [Depth];
    logic               w_unused_mtime;

    assign w_pop = core_mret_i && (r_depth != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (irq_valid_i && (r_depth < DepthMax) &&
                    ((r_depth == '0) || earlier(irq_dl_i, r_stk_dl[0]))) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CLAIM;
                end
            end
            S_CLAIM: w_state_nxt = S_NOTIFY;
            S_NOTIFY: begin
                if (core_irq_ack_i) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_pend_id <= '0;
            r_pend_dl <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pend_id <= irq_id_i;
                r_pend_dl <= irq_dl_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_depth <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_stk_id[i] <= '0;
                r_stk_dl[i] <= '0;
            end
        end else if (w_pop && !w_push) begin
            r_depth <= r_depth - 1'b1;
            for (int i = 0; i < Depth - 1; i++) begin
                r_stk_id[i] <= r_stk_id[i+1];
                r_stk_dl[i] <= r_stk_dl[i+1];
            end
            r_stk_id[Depth-1] <= '0;
            r_stk_dl[Depth-1] <= '0;
        end else if (w_push && !w_pop) begin
            r_depth     <= r_depth + 1'b1;
            r_stk_id[0] <= r_pend_id;
            r_stk_dl[0] <= r_pend_dl;
            for (int i = 1; i < Depth; i++) begin
                r_stk_id[i] <= r_stk_id[i-1];
                r_stk_dl[i] <= r_stk_dl[i-1];
            end
        end else if (w_push && w_pop) begin
            r_stk_id[0] <= r_pend_id;
            r_stk_dl[0] <= r_pend_dl;
        end
    end

    assign irq_ack_o      = (r_state == S_CLAIM);
    assign irq_id_o       = irq_ack_o ? r_pend_id : '0;
    assign core_irq_req_o = (r_state == S_NOTIFY);
    assign core_irq_id_o  = core_irq_req_o ? r_pend_id : '0;
    assign cur_id_o       = r_stk_id[0];
    assign cur_dl_o       = r_stk_dl[0];
    assign depth_o        = r_depth;

`ifdef EDF_IRQ_SINK_MISS_EN
    logic r_miss;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_miss <= 1'b0;
        end else if (w_push || w_pop) begin
            r_miss <= 1'b0;
        end else if ((r_depth != '0) && earlier(r_stk_dl[0], mtime_i[TsWidth-1:0])) begin
            r_miss <= 1'b1;
        end
    end

    assign dl_miss_o = r_miss;
`else
    assign dl_miss_o = 1'b0;
`endif

    assign w_unused_mtime = ^mtime_i;

endmodule

// File: tb/tb_edf_irq_sink.sv
// tb/tb_edf_irq_sink.sv - scoreboard bench for edf_irq_sink (claim, preempt, wrap, full, mret/push, miss, reset).
module tb_edf_irq_sink;
    localparam int NrIrqs  = 4;
    localparam int TsWidth = 24;
    localparam int Depth   = 3;
    localparam int IdW     = 2;
    localparam int DpW     = 2;
`ifdef EDF_IRQ_SINK_MISS_EN
    localparam bit MissEn = 1'b1;
`else
    localparam bit MissEn = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               irq_valid;
    logic [IdW-1:0]     irq_id;
    logic [TsWidth-1:0] irq_dl;
    logic               irq_ack;
    logic [IdW-1:0]     irq_id_out;
    logic               core_req;
    logic [IdW-1:0]     core_id;
    logic               core_ack;
    logic               core_mret;
    logic [63:0]        mtime;
    logic [IdW-1:0]     cur_id;
    logic [TsWidth-1:0] cur_dl;
    logic [DpW-1:0]     depth;
    logic               dl_miss;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [IdW-1:0] exp_q[$];

    edf_irq_sink #(.NrIrqs(NrIrqs), .TsWidth(TsWidth), .Depth(Depth)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .irq_valid_i    (irq_valid),
        .irq_id_i       (irq_id),
        .irq_dl_i       (irq_dl),
        .irq_ack_o      (irq_ack),
        .irq_id_o       (irq_id_out),
        .core_irq_req_o (core_req),
        .core_irq_id_o  (core_id),
        .core_irq_ack_i (core_ack),
        .core_mret_i    (core_mret),
        .mtime_i        (mtime),
        .cur_id_o       (cur_id),
        .cur_dl_o       (cur_dl),
        .depth_o        (depth),
        .dl_miss_o      (dl_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_top(input string tag, input int d, input int id, input int dl);
        check({tag, "_depth"}, depth, d);
        check({tag, "_cur_id"}, cur_id, id);
        check({tag, "_cur_dl"}, cur_dl, dl);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, irq_ack, 0);
        check({tag, "_irq_id"}, irq_id_out, 0);
        check({tag, "_req"}, core_req, 0);
        check({tag, "_core_id"}, core_id, 0);
        check_top(tag, 0, 0, 0);
        check({tag, "_miss"}, dl_miss, 0);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!core_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, core_req, 1);
    endtask

    task automatic serve(input int id, input int dl);
        irq_valid = 1'b1;
        irq_id    = IdW'(id);
        irq_dl    = TsWidth'(dl);
        exp_q.push_back(IdW'(id));
        tick();
        irq_valid = 1'b0;
        wait_req("serve");
        check("serve_core_id", core_id, id);
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
    endtask

    task automatic mret();
        core_mret = 1'b1;
        tick();
        core_mret = 1'b0;
    endtask

    task automatic hold_valid(input int id, input int dl, input int n);
        irq_valid = 1'b1;
        irq_id    = IdW'(id);
        irq_dl    = TsWidth'(dl);
        repeat (n) tick();
        irq_valid = 1'b0;
    endtask

    // Every claim pulse must match the next scoreboard entry; an empty queue means an unexpected claim.
    always @(negedge clk) begin
        if (rst_n && irq_ack) begin
            if (exp_q.size() == 0) check("unexp_ack", irq_ack, 0);
            else check("ack_id", irq_id_out, exp_q.pop_front());
        end
    end

    initial begin
        rst_n     = 1'b0;
        irq_valid = 1'b0;
        irq_id    = '0;
        irq_dl    = '0;
        core_ack  = 1'b0;
        core_mret = 1'b0;
        mtime     = '0;
        tick();
        tick();
        check_zero("rst");
        rst_n = 1'b1;
        tick();
        check_zero("rst_rel");

        // Basic claim/notify/push timing
        irq_valid = 1'b1;
        irq_id    = 2'd2;
        irq_dl    = 24'd100;
        exp_q.push_back(2'd2);
        tick();
        check("t040_ack", irq_ack, 1);
        irq_valid = 1'b0;
        tick();
        check("t040_ack_one", irq_ack, 0);
        check("t040_req", core_req, 1);
        check("t040_core_id", core_id, 2);
        tick();
        check("t040_req_hold", core_req, 1);
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        check("t040_req_done", core_req, 0);
        check_top("t040", 1, 2, 100);

        // Core ack outside NOTIFY is ignored
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        check_top("t030", 1, 2, 100);

        // Equal deadline does not preempt; earlier does
        hold_valid(3, 100, 5);
        check_top("t041_eq", 1, 2, 100);
        serve(1, 50);
        check_top("t041_pre", 2, 1, 50);
        hold_valid(3, 100, 4);
        check_top("t041_late", 2, 1, 50);

        mret();
        check_top("pop1", 1, 2, 100);
        mret();
        check_top("pop0", 0, 0, 0);
        mret();
        check_top("pop_empty", 0, 0, 0);

        // Wrap-around ordering
        serve(0, 'h10);
        serve(3, 'hFFFFF0);
        check_top("t042_wrap", 2, 3, 'hFFFFF0);
        mret();
        check_top("t042_pop", 1, 0, 'h10);

        // Full stack holds off a claim until a pop
        serve(1, 'h8);
        serve(2, 'h4);
        check_top("t043_full", 3, 2, 'h4);
        irq_valid = 1'b1;
        irq_id    = 2'd3;
        irq_dl    = 24'h2;
        repeat (4) tick();
        check("t043_held_depth", depth, 3);
        exp_q.push_back(2'd3);
        mret();
        check("t043_after_pop", depth, 2);
        check("t043_no_ack_yet", irq_ack, 0);
        tick();
        check("t043_ack", irq_ack, 1);
        irq_valid = 1'b0;
        wait_req("t043");
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        check_top("t043_push", 3, 3, 'h2);

        // mret and push in the same cycle replace the top
        mret();
        mret();
        mret();
        check_top("t044_empty", 0, 0, 0);
        serve(1, 500);
        irq_valid = 1'b1;
        irq_id    = 2'd2;
        irq_dl    = 24'd400;
        exp_q.push_back(2'd2);
        tick();
        irq_valid = 1'b0;
        wait_req("t044");
        core_ack  = 1'b1;
        core_mret = 1'b1;
        tick();
        core_ack  = 1'b0;
        core_mret = 1'b0;
        check_top("t044", 1, 2, 400);

        // Deadline miss
        mret();
        serve(0, 200);
        mtime = 64'd200;
        tick();
        tick();
        check("t045_miss_eq", dl_miss, 0);
        mtime = 64'd201;
        tick();
        check("t045_miss_set", dl_miss, MissEn);
        tick();
        check("t045_miss_hold", dl_miss, MissEn);
        mret();
        check("t045_miss_clr", dl_miss, 0);
        mtime = '0;

        // Reset in NOTIFY abandons the claim
        serve(1, 300);
        irq_valid = 1'b1;
        irq_id    = 2'd3;
        irq_dl    = 24'd10;
        exp_q.push_back(2'd3);
        tick();
        irq_valid = 1'b0;
        tick();
        check("t035_notify", core_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t035_in_rst");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_zero("t035_rel");

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
